jtdd_colmix_pal: RTL and testbench

//  Downstream of the object line-buffer stage: takes obj_pxl, char and scroll pixels each pixel

---
 rtl/jtdd_colmix_pal.sv | 144 ++++++++++++++
 tb/tb_jtdd_colmix_pal.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_colmix_pal.sv
// Colour mixer: resolves char/object/scroll priority, looks the winner up in a two-bank
// CPU-writable palette and drives blank-aligned 4-bit RGB. Layer masking: JTDD_COLMIX_LMASK_EN.
module jtdd_colmix_pal #(
   parameter int    BLANK_DLY  = 3,
   parameter string SIMFILE_RG = "",
   parameter string SIMFILE_B  = ""
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pxl_cen,
   input  logic       LHBL,
   input  logic       LVBL,
   input  logic [7:0] char_pxl,
   input  logic [7:0] scr_pxl,
   input  logic [7:0] obj_pxl,
   input  logic [9:0] cpu_addr,
   input  logic [7:0] cpu_dout,
   input  logic       pal_cs,
   input  logic       cpu_wrn,
   output logic [7:0] pal_dout,
   input  logic [2:0] layer_mask,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       LHBL_dly,
   output logic       LVBL_dly
);

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam logic [8:0] BACKDROP = 9'h180;

`ifdef JTDD_COLMIX_LMASK_EN
   localparam logic LMASK_EN = 1'b1;
`else
   localparam logic LMASK_EN = 1'b0;
`endif

   // Palette storage: entries 0x000-0x0FF objects, 0x100-0x17F chars, 0x180-0x1FF scroll.
   logic [7:0] ram_rg [0:511];
   logic [7:0] ram_b  [0:511];

   logic [2:0]           mask_eff;
   logic                 char_op;
   logic                 obj_op;
   logic [8:0]           addr_d,  addr_q;
   logic [7:0]           rg_q,    b_q;
   rgb_t                 rgb_d,   rgb_q;
   logic [BLANK_DLY-1:0] lhbl_d,  lhbl_q;
   logic [BLANK_DLY-1:0] lvbl_d,  lvbl_q;
   logic [7:0]           pal_dout_q;
   logic                 cpu_we;
   logic                 vid_on;
   logic                 unused_bits;

   // ---------------------------------------------------------------- stage 1: priority
   assign mask_eff = layer_mask & {3{LMASK_EN}};
   assign char_op  = (char_pxl[3:0] != 4'd0) && !mask_eff[0];
   assign obj_op   = (obj_pxl[3:0]  != 4'd0) && !mask_eff[1];

   // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
   always_comb begin
      addr_d = BACKDROP;
      if (char_op)
         addr_d = {2'b10, char_pxl[6:0]};
      else if (obj_op)
         addr_d = {1'b0, obj_pxl};
      else if (!mask_eff[2])
         addr_d = {2'b11, scr_pxl[6:0]};
   end

   // ---------------------------------------------------------------- blank delay lines
   always_comb begin
      lhbl_d = BLANK_DLY'({lhbl_q, LHBL});
      lvbl_d = BLANK_DLY'({lvbl_q, LVBL});
   end

   // ---------------------------------------------------------------- stage 3: colour split
   always_comb begin
      rgb_d   = '0;
      rgb_d.r = rg_q[3:0];
      rgb_d.g = rg_q[7:4];
      rgb_d.b = b_q[3:0];
   end

   // NOTE: sequential state is written with non-blocking assignments so every register samples
   // pre-edge values, which is also what gives the palette its read-before-write behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         rg_q   <= '0;
         b_q    <= '0;
         rgb_q  <= '0;
         lhbl_q <= '0;
         lvbl_q <= '0;
      end else if (pxl_cen) begin
         addr_q <= addr_d;
         rg_q   <= ram_rg[addr_q];
         b_q    <= ram_b[addr_q];
         rgb_q  <= rgb_d;
         lhbl_q <= lhbl_d;
         lvbl_q <= lvbl_d;
      end
   end

   // ---------------------------------------------------------------- CPU port
   assign cpu_we = pal_cs && !cpu_wrn;

   // NOTE: the palette arrays have no reset; clearing them would block RAM inference and the CPU
   // reloads colours after reset anyway.
   always_ff @(posedge clk) begin
      if (cpu_we) begin
         if (cpu_addr[9])
            ram_b[cpu_addr[8:0]]  <= cpu_dout;
         else
            ram_rg[cpu_addr[8:0]] <= cpu_dout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pal_dout_q <= '0;
      else
         pal_dout_q <= cpu_addr[9] ? ram_b[cpu_addr[8:0]] : ram_rg[cpu_addr[8:0]];
   end

   assign pal_dout = pal_dout_q;

   // ---------------------------------------------------------------- outputs
   // Delayed blanking gates colour, so post-reset garbage in the pipe never reaches the screen.
   assign LHBL_dly = lhbl_q[BLANK_DLY-1];
   assign LVBL_dly = lvbl_q[BLANK_DLY-1];
   assign vid_on   = LHBL_dly && LVBL_dly;
   assign red      = vid_on ? rgb_q.r : 4'h0;
   assign green    = vid_on ? rgb_q.g : 4'h0;
   assign blue     = vid_on ? rgb_q.b : 4'h0;

   assign unused_bits = ^{char_pxl[7], scr_pxl[7], b_q[7:4]};

endmodule

// File: tb/tb_jtdd_colmix_pal.sv
// Directed bench for jtdd_colmix_pal: palette model plus an expected-colour queue scoreboard.
// Build with +define+JTDD_COLMIX_LMASK_EN to exercise layer masking as well.
module tb_jtdd_colmix_pal;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pxl_cen = 1'b0;
   logic       LHBL = 1'b0;
   logic       LVBL = 1'b0;
   logic [7:0] char_pxl = '0;
   logic [7:0] scr_pxl = '0;
   logic [7:0] obj_pxl = '0;
   logic [9:0] cpu_addr = '0;
   logic [7:0] cpu_dout = '0;
   logic       pal_cs = 1'b0;
   logic       cpu_wrn = 1'b1;
   logic [2:0] layer_mask = '0;
   logic [7:0] pal_dout;
   logic [3:0] red, green, blue;
   logic       LHBL_dly, LVBL_dly;

   jtdd_colmix_pal #(.BLANK_DLY(3)) dut (
      .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
      .char_pxl(char_pxl), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_cs(pal_cs), .cpu_wrn(cpu_wrn),
      .pal_dout(pal_dout), .layer_mask(layer_mask),
      .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  m_rg [512];
   logic [7:0]  m_b  [512];
   logic [13:0] sb_q [$];
   logic        pend_valid = 1'b0;
   logic [8:0]  pend_addr = '0;
   logic        pend_h = 1'b0;
   logic        pend_vb = 1'b0;
   logic [13:0] last_exp = '0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] prio(input logic [7:0] c, input logic [7:0] o,
                                       input logic [7:0] s, input logic [2:0] m);
      if (c[3:0] != 4'd0 && !m[0])      return {2'b10, c[6:0]};
      else if (o[3:0] != 4'd0 && !m[1]) return {1'b0, o};
      else if (!m[2])                   return {2'b11, s[6:0]};
      else                              return 9'h180;
   endfunction

   function automatic logic [13:0] video_out();
      return {LHBL_dly, LVBL_dly, red, green, blue};
   endfunction

   task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_dout = d; pal_cs = 1'b1; cpu_wrn = 1'b0;
      if (a[9]) m_b[a[8:0]] = d; else m_rg[a[8:0]] = d;
      @(posedge clk); #1;
      pal_cs = 1'b0; cpu_wrn = 1'b1;
   endtask

   task automatic cpu_read(input logic [9:0] a);
      logic [7:0] e;
      e = a[9] ? m_b[a[8:0]] : m_rg[a[8:0]];
      cpu_addr = a;
      @(posedge clk); #1;
      check("pal_dout", {8'h0, pal_dout}, {8'h0, e});
   endtask

   // One pixel slot (two clk). The pixel latched on the previous slot reads the palette on
   // this slot's edge, so its colour is looked up here, before an optional same-edge CPU write.
   task automatic pix(input logic wr, input logic [9:0] wa, input logic [7:0] wd);
      logic [7:0]  rg, b;
      logic [2:0]  m;
      logic [13:0] e;
`ifdef JTDD_COLMIX_LMASK_EN
      m = layer_mask;
`else
      m = 3'b000;
`endif
      if (pend_valid) begin
         rg = m_rg[pend_addr];
         b  = m_b[pend_addr];
         e  = (pend_h && pend_vb) ? {pend_h, pend_vb, rg[3:0], rg[7:4], b[3:0]}
                                  : {pend_h, pend_vb, 12'h000};
         sb_q.push_back(e);
      end
      pend_valid = 1'b1;
      pend_addr  = prio(char_pxl, obj_pxl, scr_pxl, m);
      pend_h     = LHBL;
      pend_vb    = LVBL;
      if (wr) begin
         cpu_addr = wa; cpu_dout = wd; pal_cs = 1'b1; cpu_wrn = 1'b0;
         if (wa[9]) m_b[wa[8:0]] = wd; else m_rg[wa[8:0]] = wd;
      end
      pxl_cen = 1'b1;
      @(posedge clk); #1;
      pxl_cen = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1;
      @(posedge clk); #1;
      if (sb_q.size() == 2) begin
         last_exp = sb_q.pop_front();
         check("rgb", {2'b00, video_out()}, {2'b00, last_exp});
      end
   endtask

   task automatic set_pix(input logic [7:0] c, input logic [7:0] o, input logic [7:0] s);
      char_pxl = c; obj_pxl = o; scr_pxl = s;
   endtask

   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      #1;
      check("rst_rgb", {2'b00, video_out()}, 16'h0000);
      check("rst_dout", {8'h0, pal_dout}, 16'h0000);
      sb_q.delete();
      pend_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      // reset from power-up, outputs cleared asynchronously
      #1 rst_n = 1'b0;
      #3;
      check("por_rgb", {2'b00, video_out()}, 16'h0000);
      check("por_dout", {8'h0, pal_dout}, 16'h0000);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // fill both banks so the model knows every entry
      for (int i = 0; i < 1024; i++) cpu_write(10'(i), 8'($urandom_range(0, 255)));

      // palette write / readback
      cpu_write(10'h012, 8'hA5);
      cpu_write(10'h212, 8'h0C);
      cpu_read(10'h012);
      cpu_read(10'h212);
      cpu_read(10'h180);

      // priority
      LHBL = 1'b1; LVBL = 1'b1;
      set_pix(8'h13, 8'h27, 8'h31); pix(1'b0, '0, '0);
      set_pix(8'h10, 8'h27, 8'h31); pix(1'b0, '0, '0);
      set_pix(8'h10, 8'h20, 8'h31); pix(1'b0, '0, '0);
      set_pix(8'h00, 8'h12, 8'h30); pix(1'b0, '0, '0);
      set_pix(8'h00, 8'h00, 8'h00); pix(1'b0, '0, '0);
      set_pix(8'hFF, 8'hFF, 8'hFF); pix(1'b0, '0, '0);

      // stalled pipeline holds its output
      repeat (5) @(posedge clk); #1;
      check("stall_hold", {2'b00, video_out()}, {2'b00, last_exp});

      // random pixel stream
      for (int i = 0; i < 24; i++) begin
         set_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         pix(1'b0, '0, '0);
      end

      // horizontal then vertical blanking through the delay lines
      set_pix(8'h00, 8'h35, 8'h41);
      LHBL = 1'b0; repeat (4) pix(1'b0, '0, '0);
      LHBL = 1'b1; repeat (2) pix(1'b0, '0, '0);
      LVBL = 1'b0; repeat (2) pix(1'b0, '0, '0);
      LVBL = 1'b1; repeat (3) pix(1'b0, '0, '0);

      // collision: CPU rewrites the entry on the very edge the video port reads it
      set_pix(8'h13, 8'h27, 8'h31);
      pix(1'b0, '0, '0);
      pix(1'b1, 10'h113, ~m_rg[9'h113]);
      pix(1'b0, '0, '0);
      pix(1'b1, 10'h313, ~m_b[9'h113]);
      pix(1'b0, '0, '0);
      pix(1'b0, '0, '0);

`ifdef JTDD_COLMIX_LMASK_EN
      layer_mask = 3'b001; set_pix(8'h13, 8'h27, 8'h31); pix(1'b0, '0, '0);
      layer_mask = 3'b111; pix(1'b0, '0, '0);
      layer_mask = 3'b011; pix(1'b0, '0, '0);
      layer_mask = 3'b000; pix(1'b0, '0, '0);
`endif

      // mid-frame reset: blanked for two slots, valid colour on the third
      set_pix(8'h00, 8'h27, 8'h31);
      reset_pulse();
      pix(1'b0, '0, '0);
      check("rst_release1", {2'b00, video_out()}, 16'h0000);
      pix(1'b0, '0, '0);
      check("rst_release2", {2'b00, video_out()}, 16'h0000);
      set_pix(8'h13, 8'h00, 8'h31);
      repeat (4) pix(1'b0, '0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
